// File: rtl/simon_round_sequencer_pkg.sv
// rtl/simon_round_sequencer_pkg.sv - shared state, colour type and LED decode for the Simon round sequencer
package simon_pkg;

   typedef enum logic [3:0] {
      IDLE,
      APPEND,
      PLAY_RD,
      PLAY_ON,
      PLAY_OFF,
      IN_RD,
      IN_WAIT,
      CHECK,
      LOSE,
      WIN
   } state_e;

   typedef logic [1:0] color_t;

   function automatic logic [3:0] color2led(input color_t c);
      return 4'b0001 << c;
   endfunction

endpackage

// File: rtl/simon_round_sequencer_if.sv
// rtl/simon_round_sequencer_if.sv - game-side signals of the Simon round sequencer: pacing, buttons, pattern memory, display
interface simon_round_sequencer_if #(
   parameter int AW = 3
);
   import simon_pkg::*;

   logic          tick;
   logic          start;
   logic [3:0]    btn;
   color_t        rnd;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   color_t        mem_wdata;
   logic          mem_re;
   logic [AW-1:0] mem_raddr;
   color_t        mem_rdata;
   logic [3:0]    led;
   logic [AW:0]   score;
   logic          busy;
   logic          lose;
   logic          win;

   modport master (
      input  tick, start, btn, rnd, mem_rdata,
      output mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr, led, score, busy, lose, win
   );

   modport slave (
      output tick, start, btn, rnd, mem_rdata,
      input  mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr, led, score, busy, lose, win
   );

endinterface

// File: rtl/simon_tick_timer.sv
// rtl/simon_tick_timer.sv - loadable tick-gated down counter; done pulses on the tick that empties it
module simon_tick_timer #(
   parameter int W = 5
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         tick_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (tick_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = tick_i && (cnt_q == W'(1));

endmodule

// File: rtl/simon_round_sequencer.sv
// rtl/simon_round_sequencer.sv - Simon Says round controller: append, play back, check presses.
// Optional SIMON_TIMEOUT_EN: IN_WAIT loses after TO_TICKS ticks without a press.
module simon_round_sequencer
   import simon_pkg::*;
#(
   parameter int MAX_LEN   = 8,
   parameter int AW        = $clog2(MAX_LEN),
   parameter int ON_TICKS  = 4,
   parameter int OFF_TICKS = 2,
   parameter int TO_TICKS  = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   simon_round_sequencer_if.master  bus
);

   localparam int PLAY_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int T_MAX    = (TO_TICKS > PLAY_MAX) ? TO_TICKS : PLAY_MAX;
   localparam int TW       = $clog2(T_MAX + 1);
   localparam logic [AW:0] LEN_ONE = (AW+1)'(1);
   localparam logic [AW:0] LEN_MAX = (AW+1)'(MAX_LEN);

   state_e        state_q, state_d;
   logic [AW:0]   len_q, len_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [AW:0]   score_q, score_d;
   color_t        cur_q, cur_d;
   logic [3:0]    btn_q, btn_d;
   logic          rd_pend_q;
   color_t        cur_now;
   logic          idx_last;
   logic          tmr_load;
   logic [TW-1:0] tmr_val;
   logic          tmr_done;

   simon_tick_timer #(.W(TW)) u_timer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .tick_i     (bus.tick),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

   // Memory data arrives the cycle after a read, so the first PLAY_ON cycle shows it directly.
   assign cur_now  = rd_pend_q ? bus.mem_rdata : cur_q;
   assign idx_last = (({1'b0, idx_q} + LEN_ONE) == len_q);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         len_q     <= '0;
         idx_q     <= '0;
         score_q   <= '0;
         cur_q     <= '0;
         btn_q     <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         score_q   <= score_d;
         cur_q     <= cur_d;
         btn_q     <= btn_d;
         rd_pend_q <= bus.mem_re;
      end
   end

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      idx_d         = idx_q;
      score_d       = score_q;
      cur_d         = cur_now;
      btn_d         = btn_q;
      tmr_load      = 1'b0;
      tmr_val       = '0;
      bus.mem_we    = 1'b0;
      bus.mem_waddr = '0;
      bus.mem_wdata = '0;
      bus.mem_re    = 1'b0;
      bus.mem_raddr = '0;
      bus.led       = '0;

      unique case (state_q)
         IDLE, LOSE, WIN: begin
            if (bus.start) begin
               len_d   = '0;
               score_d = '0;
               state_d = APPEND;
            end
         end
         APPEND: begin
            bus.mem_we    = 1'b1;
            bus.mem_waddr = len_q[AW-1:0];
            bus.mem_wdata = bus.rnd;
            len_d         = len_q + LEN_ONE;
            idx_d         = '0;
            state_d       = PLAY_RD;
         end
         PLAY_RD: begin
            bus.mem_re    = 1'b1;
            bus.mem_raddr = idx_q;
            tmr_load      = 1'b1;
            tmr_val       = TW'(ON_TICKS);
            state_d       = PLAY_ON;
         end
         PLAY_ON: begin
            bus.led = color2led(cur_now);
            if (tmr_done) begin
               tmr_load = 1'b1;
               tmr_val  = TW'(OFF_TICKS);
               state_d  = PLAY_OFF;
            end
         end
         PLAY_OFF: begin
            if (tmr_done) begin
               if (idx_last) begin
                  idx_d   = '0;
                  state_d = IN_RD;
               end else begin
                  idx_d   = idx_q + AW'(1);
                  state_d = PLAY_RD;
               end
            end
         end
         IN_RD: begin
            bus.mem_re    = 1'b1;
            bus.mem_raddr = idx_q;
`ifdef SIMON_TIMEOUT_EN
            tmr_load      = 1'b1;
            tmr_val       = TW'(TO_TICKS);
`endif
            state_d       = IN_WAIT;
         end
         IN_WAIT: begin
            if (bus.btn != 4'b0000) begin
               btn_d   = bus.btn;
               state_d = CHECK;
            end
`ifdef SIMON_TIMEOUT_EN
            else if (tmr_done) begin
               state_d = LOSE;
            end
`endif
         end
         CHECK: begin
            if (!$onehot(btn_q) || (btn_q != color2led(cur_q))) begin
               state_d = LOSE;
            end else if (!idx_last) begin
               idx_d   = idx_q + AW'(1);
               state_d = IN_RD;
            end else begin
               score_d = score_q + LEN_ONE;
               state_d = (len_q == LEN_MAX) ? WIN : APPEND;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.score = score_q;
   assign bus.busy  = !((state_q == IDLE) || (state_q == LOSE) || (state_q == WIN));
   assign bus.lose  = (state_q == LOSE);
   assign bus.win   = (state_q == WIN);

endmodule

// File: tb/tb_simon_round_sequencer.sv
// tb/tb_simon_round_sequencer.sv - self-checking bench for simon_round_sequencer
module tb_simon_round_sequencer;
   import simon_pkg::*;

   localparam int MAX_LEN   = 8;
   localparam int AW        = 3;
   localparam int ON_TICKS  = 4;
   localparam int OFF_TICKS = 2;
   localparam int TO_TICKS  = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   simon_round_sequencer_if #(.AW(AW)) bus ();

   simon_round_sequencer #(
      .MAX_LEN(MAX_LEN), .AW(AW), .ON_TICKS(ON_TICKS), .OFF_TICKS(OFF_TICKS), .TO_TICKS(TO_TICKS)
   ) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   color_t mem [MAX_LEN];
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_raddr];
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   typedef struct {
      logic       tk;
      logic       st;
      logic [3:0] btn;
      logic [1:0] rnd;
      logic       we;
      logic [2:0] wa;
      logic [1:0] wd;
      logic       re;
      logic [2:0] ra;
      logic [3:0] led;
      logic       busy;
      logic       lose;
      logic [3:0] score;
   } vec_t;

   vec_t tbl[$];

   task automatic row(input logic tk, st, input logic [3:0] btn, input logic [1:0] rnd,
                      input logic we, input logic [2:0] wa, input logic [1:0] wd,
                      input logic re, input logic [2:0] ra, input logic [3:0] led,
                      input logic busy, lose, input logic [3:0] score);
      vec_t v;
      v = '{tk, st, btn, rnd, we, wa, wd, re, ra, led, busy, lose, score};
      tbl.push_back(v);
   endtask

   task automatic check_idle_outputs(input string nm);
      chk({nm, "_we"},    int'(bus.mem_we), 0);
      chk({nm, "_re"},    int'(bus.mem_re), 0);
      chk({nm, "_led"},   int'(bus.led), 0);
      chk({nm, "_busy"},  int'(bus.busy), 0);
      chk({nm, "_lose"},  int'(bus.lose), 0);
      chk({nm, "_win"},   int'(bus.win), 0);
      chk({nm, "_score"}, int'(bus.score), 0);
      chk({nm, "_addr"},  int'({bus.mem_waddr, bus.mem_raddr}), 0);
   endtask

   // Starts a one-step game with colour c and returns in the cycle of the first input read.
   task automatic to_in_wait(input color_t c);
      int n;
      n = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.rnd = c; bus.tick = 1'b1; bus.btn = 4'b0000;
      for (int i = 0; i < 100 && n < 2; i++) begin
         @(negedge clk);
         bus.start = 1'b0; bus.tick = 1'b1; bus.btn = 4'b0000;
         #1;
         if (bus.mem_re) n++;
      end
      chk("reach_in_wait", n, 2);
   endtask

   // One complete game driven with random ticks; err_round = 0 plays perfectly.
   task automatic play_game(input int err_round, input int budget);
      color_t     pat[$];
      int         reads, pulse, ticks, gap, press_wait, in_idx, expect_at, expect_kind, len;
      logic [3:0] prev_led, next_btn, pv;
      bit         pressing, gap_on, done;
      pat = {};
      reads = 0; pulse = 0; ticks = 0; gap = 0; press_wait = 0; in_idx = 0;
      expect_at = -1; expect_kind = 0; prev_led = 4'b0000; next_btn = 4'b0000;
      pressing = 1'b0; gap_on = 1'b0; done = 1'b0;
      for (int cyc = 0; cyc < budget && !done; cyc++) begin
         @(negedge clk);
         bus.start = (cyc == 0);
         bus.tick  = ($urandom_range(0, 2) != 0);
         bus.rnd   = color_t'($urandom);
         bus.btn   = next_btn;
         next_btn  = 4'b0000;
         #1;
         len = pat.size();
         if (cyc == 1) chk("start_to_we", int'(bus.mem_we), 1);
         if (bus.mem_we) begin
            chk("append_addr",  int'(bus.mem_waddr), len);
            chk("append_data",  int'(bus.mem_wdata), int'(bus.rnd));
            chk("append_score", int'(bus.score), len);
            pat.push_back(bus.rnd);
            len = pat.size();
            reads = 0; pulse = 0;
         end
         if (bus.led != 4'b0000) begin
            if (prev_led == 4'b0000) begin
               if (pulse < len) chk("play_led", int'(bus.led), int'(color2led(pat[pulse])));
               ticks = 0;
            end
            if (bus.tick) ticks++;
         end else if (prev_led != 4'b0000) begin
            chk("on_ticks", ticks, ON_TICKS);
            pulse++;
            gap_on = 1'b1; gap = 0;
         end
         prev_led = bus.led;
         if (gap_on) begin
            if (bus.mem_re) begin
               chk("off_ticks", gap, OFF_TICKS);
               gap_on = 1'b0;
            end else if (bus.tick) begin
               gap++;
            end
         end
         if (bus.mem_re) begin
            if (reads < len) begin
               chk("play_raddr", int'(bus.mem_raddr), reads);
            end else begin
               in_idx = reads - len;
               chk("in_raddr", int'(bus.mem_raddr), in_idx);
               pressing   = 1'b1;
               press_wait = $urandom_range(0, 3);
            end
            reads++;
         end
         if (cyc == expect_at) begin
            case (expect_kind)
               1: begin
                  chk("lose_level", int'(bus.lose), 1);
                  chk("lose_busy",  int'(bus.busy), 0);
                  chk("lose_score", int'(bus.score), len - 1);
                  done = 1'b1;
               end
               2: begin
                  chk("win_level", int'(bus.win), 1);
                  chk("win_busy",  int'(bus.busy), 0);
                  chk("win_score", int'(bus.score), MAX_LEN);
                  done = 1'b1;
               end
               3: chk("next_append", int'(bus.mem_we), 1);
               default: chk("next_in_rd", int'(bus.mem_re), 1);
            endcase
         end
         if (pressing) begin
            if (press_wait == 0 && in_idx < len) begin
               pv = color2led(pat[in_idx]);
               if (len == err_round && in_idx == (len - 1) / 2) begin
                  case ($urandom_range(0, 2))
                     0:       pv = color2led(color_t'(pat[in_idx] + 2'd1));
                     1:       pv = pv | color2led(color_t'(pat[in_idx] + 2'd2));
                     default: pv = 4'b1111;
                  endcase
                  expect_kind = 1;
               end else if (in_idx == len - 1) begin
                  expect_kind = (len == MAX_LEN) ? 2 : 3;
               end else begin
                  expect_kind = 4;
               end
               next_btn  = pv;
               expect_at = cyc + 3;
               pressing  = 1'b0;
            end else begin
               press_wait--;
            end
         end else if (reads >= 1 && reads <= len && $urandom_range(0, 3) == 0) begin
            next_btn = 4'($urandom_range(1, 15));
         end
      end
      chk("game_finished", int'(done), 1);
   endtask

   initial begin
      bus.tick = 1'b0; bus.start = 1'b0; bus.btn = 4'b0000; bus.rnd = 2'd0;

      //   tk st btn rnd  we wa wd re ra led  busy lose score
      row(1, 1, 0, 0,   0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
      row(1, 0, 0, 2,   1, 0, 2, 0, 0, 4'h0, 1, 0, 0);
      row(1, 0, 0, 0,   0, 0, 0, 1, 0, 4'h0, 1, 0, 0);
      row(1, 0, 0, 0,   0, 0, 0, 0, 0, 4'h4, 1, 0, 0);
      row(0, 0, 0, 0,   0, 0, 0, 0, 0, 4'h4, 1, 0, 0);
      row(1, 0, 1, 0,   0, 0, 0, 0, 0, 4'h4, 1, 0, 0);
      row(1, 1, 0, 0,   0, 0, 0, 0, 0, 4'h4, 1, 0, 0);
      row(1, 0, 0, 0,   0, 0, 0, 0, 0, 4'h4, 1, 0, 0);
      row(1, 0, 0, 0,   0, 0, 0, 0, 0, 4'h0, 1, 0, 0);
      row(1, 0, 0, 0,   0, 0, 0, 0, 0, 4'h0, 1, 0, 0);
      row(1, 0, 0, 0,   0, 0, 0, 1, 0, 4'h0, 1, 0, 0);
      row(1, 0, 4, 0,   0, 0, 0, 0, 0, 4'h0, 1, 0, 0);
      row(1, 0, 0, 0,   0, 0, 0, 0, 0, 4'h0, 1, 0, 0);
      row(1, 0, 0, 1,   1, 1, 1, 0, 0, 4'h0, 1, 0, 1);
      row(1, 0, 0, 0,   0, 0, 0, 1, 0, 4'h0, 1, 0, 1);
      for (int i = 0; i < 4; i++) row(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h4, 1, 0, 1);
      for (int i = 0; i < 2; i++) row(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 0, 1);
      row(1, 0, 0, 0,   0, 0, 0, 1, 1, 4'h0, 1, 0, 1);
      for (int i = 0; i < 4; i++) row(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h2, 1, 0, 1);
      for (int i = 0; i < 2; i++) row(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 0, 1);
      row(1, 0, 0, 0,   0, 0, 0, 1, 0, 4'h0, 1, 0, 1);
      row(1, 1, 1, 0,   0, 0, 0, 0, 0, 4'h0, 1, 0, 1);
      row(1, 0, 0, 0,   0, 0, 0, 0, 0, 4'h0, 1, 0, 1);
      row(1, 0, 0, 0,   0, 0, 0, 0, 0, 4'h0, 0, 1, 1);
      row(1, 1, 0, 0,   0, 0, 0, 0, 0, 4'h0, 0, 1, 1);
      row(1, 0, 0, 3,   1, 0, 3, 0, 0, 4'h0, 1, 0, 0);
      row(1, 0, 0, 0,   0, 0, 0, 1, 0, 4'h0, 1, 0, 0);
      row(1, 0, 0, 0,   0, 0, 0, 0, 0, 4'h8, 1, 0, 0);

      repeat (3) @(negedge clk);
      #1;
      check_idle_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         bus.tick = tbl[i].tk; bus.start = tbl[i].st; bus.btn = tbl[i].btn; bus.rnd = tbl[i].rnd;
         #1;
         chk($sformatf("v%0d_we", i),    int'(bus.mem_we),    int'(tbl[i].we));
         chk($sformatf("v%0d_waddr", i), int'(bus.mem_waddr), int'(tbl[i].wa));
         chk($sformatf("v%0d_wdata", i), int'(bus.mem_wdata), int'(tbl[i].wd));
         chk($sformatf("v%0d_re", i),    int'(bus.mem_re),    int'(tbl[i].re));
         chk($sformatf("v%0d_raddr", i), int'(bus.mem_raddr), int'(tbl[i].ra));
         chk($sformatf("v%0d_led", i),   int'(bus.led),       int'(tbl[i].led));
         chk($sformatf("v%0d_busy", i),  int'(bus.busy),      int'(tbl[i].busy));
         chk($sformatf("v%0d_lose", i),  int'(bus.lose),      int'(tbl[i].lose));
         chk($sformatf("v%0d_win", i),   int'(bus.win),       0);
         chk($sformatf("v%0d_score", i), int'(bus.score),     int'(tbl[i].score));
         @(negedge clk);
      end

      // Asynchronous reset in the middle of PLAY_ON clears everything without a clock edge.
      bus.start = 1'b0; bus.btn = 4'b0000; bus.tick = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      @(negedge clk);
      rst_n = 1'b1;

      to_in_wait(2'd0);
      @(negedge clk); bus.btn = 4'b0011; #1;
      @(negedge clk); bus.btn = 4'b0000; #1;
      chk("multihot_check_cycle", int'(bus.lose), 0);
      @(negedge clk); #1;
      chk("multihot_lose", int'(bus.lose), 1);
      chk("multihot_busy", int'(bus.busy), 0);

      play_game(0, 6000);
      for (int g = 0; g < 4; g++) play_game($urandom_range(1, MAX_LEN), 6000);

`ifdef SIMON_TIMEOUT_EN
      to_in_wait(2'd1);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk); bus.tick = 1'b1; bus.btn = 4'b0000; #1;
      end
      chk("timeout_not_yet", int'(bus.lose), 0);
      @(negedge clk); #1;
      chk("timeout_lose", int'(bus.lose), 1);

      to_in_wait(2'd0);
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk); bus.tick = 1'b1; bus.btn = (k == 15) ? 4'b0001 : 4'b0000; #1;
      end
      @(negedge clk); bus.btn = 4'b0000; #1;
      @(negedge clk); #1;
      chk("late_press_lose", int'(bus.lose), 0);
      chk("late_press_append", int'(bus.mem_we), 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/simon_round_sequencer.md
Name: simon_round_sequencer

Overview:
- Round controller for the Simon Says game. Each round it appends one random step to the pattern memory, plays the pattern back on the LEDs, then checks the player's button presses against memory.
- Sits between the random generator, the pattern memory (synchronous read) and the LED/seven-segment outputs.
- Owns all memory read and write sequencing.

Parameters:
- MAX_LEN, 8, maximum pattern length; reaching it ends the game in WIN.
- AW, $clog2(MAX_LEN), memory address width.
- ON_TICKS, 4, tick count an LED stays lit during playback.
- OFF_TICKS, 2, tick count of dark gap between playback steps.
- TO_TICKS, 16, input timeout in ticks (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick  in  1  single-cycle pacing strobe from the clock divider
- start  in  1  pulse; begins a new game from IDLE, LOSE or WIN
- btn  in  4  debounced one-hot button press pulses, one cycle wide
- rnd  in  2  random step value from the generator
- mem_we  out  1  pattern memory write enable
- mem_waddr  out  AW  write address
- mem_wdata  out  2  write data
- mem_re  out  1  read enable
- mem_raddr  out  AW  read address
- mem_rdata  in  2  read data, valid the cycle after mem_re
- led  out  4  one-hot playback LED
- score  out  AW+1  completed rounds
- busy  out  1  high outside IDLE, LOSE and WIN
- lose  out  1  level, high in LOSE
- win  out  1  level, high in WIN

Behaviour:
- Reset values: all outputs 0; state = IDLE; len = 0; idx = 0; tick counter = 0.
- Reset asserted mid-operation aborts immediately and returns to IDLE.
- State transitions:
  - IDLE, LOSE or WIN --start--> APPEND; clears len, score and win/lose.
  - APPEND: for one cycle, mem_we = 1, mem_waddr = len, mem_wdata = rnd. Then len += 1, idx = 0, go to PLAY_RD.
  - PLAY_RD: mem_re = 1, mem_raddr = idx. Next cycle go to PLAY_ON and latch mem_rdata as cur.
  - PLAY_ON: led = 1 << cur. After ON_TICKS ticks, go to PLAY_OFF.
  - PLAY_OFF: led = 0. After OFF_TICKS ticks: if idx = len-1, set idx = 0 and go to IN_RD; otherwise idx += 1 and go to PLAY_RD.
  - IN_RD: same read as PLAY_RD; latch cur, then go to IN_WAIT.
  - IN_WAIT: ignore btn == 0. On any nonzero btn, go to CHECK and latch btn.
  - CHECK:
    - If the latched btn is not exactly one-hot, or is not equal to 1 << cur, go to LOSE.
    - Else if idx < len-1: idx += 1, go to IN_RD.
    - Else score += 1. If len == MAX_LEN go to WIN, otherwise go to APPEND.
- Tick counting: the counter advances only on cycles where tick = 1 and resets on every state entry. Exactly ON_TICKS tick pulses are counted.
- Edge cases:
  - btn asserted during any playback state is ignored.
  - start asserted while busy is ignored.
  - Simultaneous btn and start in IN_WAIT: btn wins.
  - len never exceeds MAX_LEN; address increments never wrap, because len is bounded.
- Latency:
  - start to first mem_we: 1 cycle.
  - btn to LOSE/APPEND decision: 2 cycles.

Optional Feature:
- Macro SIMON_TIMEOUT_EN.
- Defined: IN_WAIT counts ticks, and reaching TO_TICKS with no press goes to LOSE. The counter restarts on each IN_WAIT entry.
- Undefined: IN_WAIT waits indefinitely, and TO_TICKS is unused.

Decomposition:
- Package simon_pkg holds:
  - typedef state_e (IDLE, APPEND, PLAY_RD, PLAY_ON, PLAY_OFF, IN_RD, IN_WAIT, CHECK, LOSE, WIN);
  - typedef color_t = logic [1:0];
  - function color2led.
- One sub-module, simon_tick_timer: loadable tick-gated down counter with a done flag, instanced once and shared by the playback and timeout phases.

Test Plan:
- Reset, then start with rnd = 2: mem_we on cycle 1 with waddr 0, wdata 2. Then led = 4'b0100 for exactly 4 ticks, followed by 2 dark ticks.
- Round 1: press btn = 4'b0100 → score = 1 and a second APPEND with waddr 1. Playback of the 2-step pattern shows steps in address order.
- Wrong press: pattern {1}, btn = 4'b0001 → lose = 1 two cycles later, busy = 0. A following start clears lose and writes address 0.
- Multi-hot press btn = 4'b0011 → LOSE. btn pulses during PLAY_ON → ignored; led and state are unchanged.
- MAX_LEN = 2 with correct presses throughout → win = 1 and score = 2. Reset asserted during PLAY_ON → all outputs 0 immediately.
- With SIMON_TIMEOUT_EN: no press for 16 ticks in IN_WAIT → LOSE. A press at tick 15 → no timeout.
